// File: rtl/blinds_motor_driver.sv
// -----------------------------------------------------------------------------
// blinds_motor_driver
//
// Drives the blinds motor H-bridge toward the position requested by
// window_blinds_automation. The motor runs until the matching end-of-travel
// limit switch closes. Every start and every reversal is preceded by a
// motor-off dead time. The driver faults if travel takes too long, or if both
// limit switches read active at the same time.
//
// Optional feature (compile-time macro BLINDS_FAULT_RETRY_EN):
//   When defined, a travel-timeout fault returns to IDLE on its own after
//   RETRY_DELAY cycles, once. A second timeout before the target limit is
//   reached latches the fault. Both-limits faults always latch.
//   When undefined, every fault latches until fault_clr or rst.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous, active-high reset
//   blinds_open  in   target position (1=open, 0=closed), same clock domain
//   limit_open   in   asynchronous open end-stop switch (1=reached)
//   limit_closed in   asynchronous closed end-stop switch (1=reached)
//   fault_clr    in   single-cycle pulse that clears FAULT
//   motor_up     out  H-bridge drive, opening direction
//   motor_down   out  H-bridge drive, closing direction
//   at_open      out  synchronised limit_open
//   at_closed    out  synchronised limit_closed
//   fault        out  high while in FAULT
//   fault_cause  out  01=travel timeout, 10=both limits active, 00=none
//
// The FSM state is held in the register 'state' (type state_t), and the
// direction in 'dir'. Checkers can bind to these registers directly.
// -----------------------------------------------------------------------------
module blinds_motor_driver #(
    parameter int DEADTIME       = 4,
    parameter int TRAVEL_TIMEOUT = 50000000,
    parameter int RETRY_DELAY    = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       blinds_open,
    input  logic       limit_open,
    input  logic       limit_closed,
    input  logic       fault_clr,
    output logic       motor_up,
    output logic       motor_down,
    output logic       at_open,
    output logic       at_closed,
    output logic       fault,
    output logic [1:0] fault_cause
);

    // One shared counter serves the dead time, the travel timer and the retry
    // delay. Only one of them is active in any given state. The width is
    // sized for the largest terminal value, so the counter can never wrap.
    localparam int MAX_A = (DEADTIME > TRAVEL_TIMEOUT) ? DEADTIME : TRAVEL_TIMEOUT;
    localparam int MAX_V = (MAX_A > RETRY_DELAY) ? MAX_A : RETRY_DELAY;
    localparam int CW    = $clog2(MAX_V + 1);

    localparam logic [CW-1:0] DEAD_LAST   = CW'(DEADTIME - 1);
    localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_TIMEOUT - 1);
`ifdef BLINDS_FAULT_RETRY_EN
    localparam logic [CW-1:0] RETRY_LAST  = CW'(RETRY_DELAY - 1);
`endif

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
    localparam logic [1:0] CAUSE_LIMITS  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DEAD    = 3'd1,
        S_OPENING = 3'd2,
        S_CLOSING = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    state_t        state, state_n;
    logic          dir, dir_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    cause, cause_n;
`ifdef BLINDS_FAULT_RETRY_EN
    logic          retry_used, retry_n;
`endif

    // Two-flop synchronisers for the asynchronous end-stop switches.
    logic lim_o_m, lim_o_s;
    logic lim_c_m, lim_c_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            lim_o_m <= 1'b0;
            lim_o_s <= 1'b0;
            lim_c_m <= 1'b0;
            lim_c_s <= 1'b0;
        end else begin
            lim_o_m <= limit_open;
            lim_o_s <= lim_o_m;
            lim_c_m <= limit_closed;
            lim_c_s <= lim_c_m;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            dir        <= 1'b0;
            cnt        <= '0;
            cause      <= CAUSE_NONE;
`ifdef BLINDS_FAULT_RETRY_EN
            retry_used <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            dir        <= dir_n;
            cnt        <= cnt_n;
            cause      <= cause_n;
`ifdef BLINDS_FAULT_RETRY_EN
            retry_used <= retry_n;
`endif
        end
    end

    // Next-state logic. Every transition clears the counter, so each state
    // starts timing from zero.
    always_comb begin
        state_n = state;
        dir_n   = dir;
        cnt_n   = cnt;
        cause_n = cause;
`ifdef BLINDS_FAULT_RETRY_EN
        retry_n = retry_used;
`endif
        if (state != S_FAULT && lim_o_s && lim_c_s) begin
            // Both end-stops closed at once means a broken switch or wiring
            // fault. This check overrides every other transition.
            state_n = S_FAULT;
            cause_n = CAUSE_LIMITS;
            cnt_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (blinds_open && !lim_o_s) begin
                        state_n = S_DEAD;
                        dir_n   = 1'b1;
                        cnt_n   = '0;
                    end else if (!blinds_open && !lim_c_s) begin
                        state_n = S_DEAD;
                        dir_n   = 1'b0;
                        cnt_n   = '0;
                    end
                end
                S_DEAD: begin
                    // The direction follows the latest target at the exit
                    // edge. A change in target during DEAD does not restart
                    // the dead time.
                    if (cnt == DEAD_LAST) begin
                        dir_n   = blinds_open;
                        state_n = blinds_open ? S_OPENING : S_CLOSING;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_OPENING: begin
                    // The limit check comes before the timeout check, so a
                    // limit that arrives on the last allowed cycle still wins.
                    if (lim_o_s) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
`ifdef BLINDS_FAULT_RETRY_EN
                        retry_n = 1'b0;
`endif
                    end else if (!blinds_open) begin
                        state_n = S_DEAD;
                        dir_n   = 1'b0;
                        cnt_n   = '0;
                    end else if (cnt == TRAVEL_LAST) begin
                        state_n = S_FAULT;
                        cause_n = CAUSE_TIMEOUT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_CLOSING: begin
                    if (lim_c_s) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
`ifdef BLINDS_FAULT_RETRY_EN
                        retry_n = 1'b0;
`endif
                    end else if (blinds_open) begin
                        state_n = S_DEAD;
                        dir_n   = 1'b1;
                        cnt_n   = '0;
                    end else if (cnt == TRAVEL_LAST) begin
                        state_n = S_FAULT;
                        cause_n = CAUSE_TIMEOUT;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_FAULT: begin
                    if (fault_clr) begin
                        state_n = S_IDLE;
                        cause_n = CAUSE_NONE;
                        cnt_n   = '0;
`ifdef BLINDS_FAULT_RETRY_EN
                        retry_n = 1'b0;
`endif
                    end
`ifdef BLINDS_FAULT_RETRY_EN
                    // Only the first timeout since the last successful
                    // travel returns to IDLE on its own.
                    else if (cause == CAUSE_TIMEOUT && !retry_used) begin
                        if (cnt == RETRY_LAST) begin
                            state_n = S_IDLE;
                            cause_n = CAUSE_NONE;
                            cnt_n   = '0;
                            retry_n = 1'b1;
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
`endif
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the registered state, so the two motor
    // drives can never be high at the same time.
    assign motor_up    = (state == S_OPENING);
    assign motor_down  = (state == S_CLOSING);
    assign fault       = (state == S_FAULT);
    assign fault_cause = cause;
    assign at_open     = lim_o_s;
    assign at_closed   = lim_c_s;

endmodule

// File: tb/tb_blinds_motor_driver.sv
// -----------------------------------------------------------------------------
// Testbench for blinds_motor_driver.
//
// The reference model tracks the driver as a phase with a countdown of the
// cycles left in that phase. Each output of the DUT is compared with the model
// on every cycle. Directed steps also check the dead-time, travel and fault
// timings against fixed counts. A randomized section then toggles the target,
// the limit switches, fault_clr and rst.
// -----------------------------------------------------------------------------
module tb_blinds_motor_driver;

    localparam int DEADTIME       = 4;
    localparam int TRAVEL_TIMEOUT = 20;
    localparam int RETRY_DELAY    = 8;
`ifdef BLINDS_FAULT_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_DEAD  = 1;
    localparam int P_OPEN  = 2;
    localparam int P_CLOSE = 3;
    localparam int P_FAULT = 4;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       blinds_open = 1'b0;
    logic       limit_open = 1'b0;
    logic       limit_closed = 1'b0;
    logic       fault_clr = 1'b0;
    logic       motor_up, motor_down, at_open, at_closed, fault;
    logic [1:0] fault_cause;

    always #5 clk = ~clk;

    blinds_motor_driver #(
        .DEADTIME      (DEADTIME),
        .TRAVEL_TIMEOUT(TRAVEL_TIMEOUT),
        .RETRY_DELAY   (RETRY_DELAY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .blinds_open (blinds_open),
        .limit_open  (limit_open),
        .limit_closed(limit_closed),
        .fault_clr   (fault_clr),
        .motor_up    (motor_up),
        .motor_down  (motor_down),
        .at_open     (at_open),
        .at_closed   (at_closed),
        .fault       (fault),
        .fault_cause (fault_cause)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    // ---------------- reference model state ----------------
    int         m_phase = P_IDLE;
    int         m_left  = 0;
    logic [1:0] m_cause = 2'b00;
    bit         m_used  = 1'b0;
    bit         m_lo1 = 1'b0, m_lo2 = 1'b0, m_lc1 = 1'b0, m_lc2 = 1'b0;

    // Advances the model by one clock edge, using the inputs as the DUT sees
    // them at that edge.
    task automatic model_step();
        bit lo, lc, up;
        lo = m_lo2;
        lc = m_lc2;
        if (rst) begin
            m_phase = P_IDLE;
            m_left  = 0;
            m_cause = 2'b00;
            m_used  = 1'b0;
            m_lo1 = 1'b0; m_lo2 = 1'b0; m_lc1 = 1'b0; m_lc2 = 1'b0;
            return;
        end
        m_lo2 = m_lo1; m_lo1 = limit_open;
        m_lc2 = m_lc1; m_lc1 = limit_closed;
        if (m_phase != P_FAULT && lo && lc) begin
            m_phase = P_FAULT;
            m_cause = 2'b10;
            return;
        end
        case (m_phase)
            P_IDLE: begin
                if ((blinds_open && !lo) || (!blinds_open && !lc)) begin
                    m_phase = P_DEAD;
                    m_left  = DEADTIME;
                end
            end
            P_DEAD: begin
                m_left--;
                if (m_left == 0) begin
                    m_phase = blinds_open ? P_OPEN : P_CLOSE;
                    m_left  = TRAVEL_TIMEOUT;
                end
            end
            P_OPEN, P_CLOSE: begin
                up = (m_phase == P_OPEN);
                if (up ? lo : lc) begin
                    m_phase = P_IDLE;
                    m_used  = 1'b0;
                end else if (blinds_open != up) begin
                    m_phase = P_DEAD;
                    m_left  = DEADTIME;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = P_FAULT;
                        m_cause = 2'b01;
                        m_left  = RETRY_DELAY;
                    end
                end
            end
            P_FAULT: begin
                if (fault_clr) begin
                    m_phase = P_IDLE;
                    m_cause = 2'b00;
                    m_used  = 1'b0;
                end else if (RETRY_EN && m_cause == 2'b01 && !m_used) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = P_IDLE;
                        m_cause = 2'b00;
                        m_used  = 1'b1;
                    end
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: the model advances with the edge, and the outputs are
    // compared with the model at the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("motor_up",    motor_up,    (m_phase == P_OPEN));
        chk("motor_down",  motor_down,  (m_phase == P_CLOSE));
        chk("fault",       fault,       (m_phase == P_FAULT));
        chk("fault_cause", fault_cause, m_cause);
        chk("at_open",     at_open,     m_lo2);
        chk("at_closed",   at_closed,   m_lc2);
        chk("motor_excl",  motor_up & motor_down, 0);
    endtask

    // Steps until the selected motor is driven, and counts the steps where it
    // was still off. A negative exp_zeros checks only that the motor starts.
    task automatic wait_motor(input string tag, input bit want_up, input int exp_zeros);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            step();
            if (want_up ? motor_up : motor_down) seen = 1'b1;
            else n++;
        end
        chk({tag, "_started"}, seen, 1);
        if (exp_zeros >= 0) chk(tag, n, exp_zeros);
    endtask

    // Counts steps until the selected motor is no longer driven.
    task automatic steps_until_low(input bit want_up, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while ((want_up ? motor_up : motor_down) && n < 200);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;

        // Reset state.
        rst = 1'b1;
        repeat (3) step();
        chk("rst_motor_up",    motor_up,    0);
        chk("rst_motor_down",  motor_down,  0);
        chk("rst_fault",       fault,       0);
        chk("rst_fault_cause", fault_cause, 0);

        // 1: close from reset, then stop on limit_closed.
        rst = 1'b0;
        wait_motor("t1_dead_cycles", 1'b0, DEADTIME);
        limit_closed = 1'b1;
        steps_until_low(1'b0, n);
        chk("t1_down_fall_edges", n, 3);
        chk("t1_at_closed", at_closed, 1);

        // 2: open from closed, limit_open after 10 cycles of travel.
        blinds_open  = 1'b1;
        limit_closed = 1'b0;
        wait_motor("t2_dead_cycles", 1'b1, DEADTIME);
        repeat (9) step();
        limit_open = 1'b1;
        steps_until_low(1'b1, n);
        chk("t2_up_fall_edges", n, 3);
        chk("t2_at_open", at_open, 1);
        chk("t2_idle_motor_up", motor_up, 0);

        // 3: reversal after 5 cycles of opening.
        limit_open = 1'b0;
        wait_motor("t3_restart", 1'b1, 2 + DEADTIME);
        repeat (4) step();
        blinds_open = 1'b0;
        wait_motor("t3_reversal_gap", 1'b0, DEADTIME);
        limit_closed = 1'b1;
        steps_until_low(1'b0, n);
        chk("t3_down_fall_edges", n, 3);

        // 4: opening timeout, then fault_clr and a fresh start.
        blinds_open  = 1'b1;
        limit_closed = 1'b0;
        wait_motor("t4_dead_cycles", 1'b1, DEADTIME);
        steps_until_low(1'b1, n);
        chk("t4_travel_cycles", n, TRAVEL_TIMEOUT);
        chk("t4_fault", fault, 1);
        chk("t4_cause", fault_cause, 2'b01);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("t4_cleared_fault", fault, 0);
        chk("t4_cleared_cause", fault_cause, 0);
        wait_motor("t4_retry_dead", 1'b1, DEADTIME);
        limit_open = 1'b1;
        steps_until_low(1'b1, n);
        chk("t4_stop_edges", n, 3);

        // 5: both limits during closing, then a limit on the last cycle of travel.
        blinds_open = 1'b0;
        limit_open  = 1'b0;
        wait_motor("t5_dead_cycles", 1'b0, DEADTIME);
        limit_open   = 1'b1;
        limit_closed = 1'b1;
        steps_until_low(1'b0, n);
        chk("t5_both_edges", n, 3);
        chk("t5_fault", fault, 1);
        chk("t5_cause", fault_cause, 2'b10);
        limit_open   = 1'b0;
        limit_closed = 1'b0;
        repeat (RETRY_DELAY + 4) step();
        chk("t5_latched", fault, 1);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("t5_cleared", fault, 0);
        wait_motor("t5_reclose_dead", 1'b0, DEADTIME);
        repeat (TRAVEL_TIMEOUT - 3) step();
        limit_closed = 1'b1;
        steps_until_low(1'b0, n);
        chk("t5_edge_stop", n, 3);
        chk("t5_edge_no_fault", fault, 0);
        chk("t5_edge_cause", fault_cause, 0);

`ifdef BLINDS_FAULT_RETRY_EN
        // 6: first timeout retries on its own, the second one latches.
        blinds_open  = 1'b1;
        limit_closed = 1'b0;
        wait_motor("t6_dead_cycles", 1'b1, DEADTIME);
        steps_until_low(1'b1, n);
        chk("t6_travel_cycles", n, TRAVEL_TIMEOUT);
        chk("t6_fault", fault, 1);
        n = 0;
        while (fault && n < 200) begin
            step();
            n++;
        end
        chk("t6_retry_delay", n, RETRY_DELAY);
        chk("t6_retry_cause", fault_cause, 0);
        wait_motor("t6_retry_dead", 1'b1, DEADTIME);
        steps_until_low(1'b1, n);
        chk("t6_second_travel", n, TRAVEL_TIMEOUT);
        repeat (120) step();
        chk("t6_latched", fault, 1);
        chk("t6_latched_cause", fault_cause, 2'b01);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        chk("t6_cleared", fault, 0);
`endif

        // Randomized section, checked against the model on every cycle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) blinds_open = ~blinds_open;
            if ($urandom_range(0, 24) == 0) limit_open = ~limit_open;
            if ($urandom_range(0, 24) == 0) limit_closed = ~limit_closed;
            fault_clr = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;
        fault_clr = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/blinds_motor_driver.md
Name: blinds_motor_driver

Overview:
- Downstream stage of window_blinds_automation: consumes its blinds_open level and drives the blinds motor H-bridge (up/down) until the matching end-of-travel limit switch closes.
- Enforces reversal dead time, travel timeout and limit-switch sanity checking.
- Reports a latched fault to the home controller.

Parameters:
- DEADTIME, 4, motor-off cycles enforced before any motor start or reversal (>=1)
- TRAVEL_TIMEOUT, 50000000, max cycles motor may run without reaching the target limit (>=2)
- RETRY_DELAY, 1000, cycles spent in FAULT before auto-retry (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- blinds_open  in  1  target from window_blinds_automation (1=open, 0=closed), same clock domain, used unsynchronised
- limit_open  in  1  asynchronous open end-stop switch (1=reached)
- limit_closed  in  1  asynchronous closed end-stop switch (1=reached)
- fault_clr  in  1  single-cycle pulse, clears FAULT
- motor_up  out  1  H-bridge drive, opening direction
- motor_down  out  1  H-bridge drive, closing direction
- at_open  out  1  synchronised limit_open
- at_closed  out  1  synchronised limit_closed
- fault  out  1  high while in FAULT
- fault_cause  out  2  01=travel timeout, 10=both limits active, 00=none

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high.
- Limit synchronisation: limit_open and limit_closed each pass through a 2-FF synchroniser. The second stages are lim_o_s and lim_c_s, driven directly on at_open and at_closed. Input-to-use latency is 2 cycles.
- States: IDLE, DEAD, OPENING, CLOSING, FAULT. A direction register dir is 1 for up, 0 for down.
- Outputs decode from the registered state:
  - motor_up = (state==OPENING)
  - motor_down = (state==CLOSING)
  - Both motor outputs are never high together.
- Reset values: state=IDLE, dir=0, counters=0, synchroniser flops=0; all outputs 0, fault_cause=00.
- Global priority: lim_o_s & lim_c_s in any non-FAULT state -> FAULT with cause 10 at the next edge. This overrides every other transition.
- IDLE:
  - blinds_open=1 & !lim_o_s -> DEAD, dir=1.
  - blinds_open=0 & !lim_c_s -> DEAD, dir=0.
  - Otherwise stay.
- DEAD:
  - Counter clears on entry; state is held exactly DEADTIME cycles.
  - Exit to OPENING if dir=1, CLOSING if dir=0. Travel counter clears on exit.
  - blinds_open changing during DEAD: dir is re-evaluated on the exit edge and the counter does not restart.
- OPENING, evaluated in this priority order:
  1. lim_o_s -> IDLE.
  2. blinds_open=0 -> DEAD, dir=0 (reversal).
  3. Travel counter == TRAVEL_TIMEOUT-1 -> FAULT, cause 01.
  4. Otherwise counter increments.
  - Net effect: the motor runs at most TRAVEL_TIMEOUT cycles, and a limit arriving on the timeout cycle wins.
- CLOSING: symmetric to OPENING, using lim_c_s and blinds_open=1.
- FAULT:
  - Motors off, fault=1, fault_cause held.
  - fault_clr -> IDLE with fault_cause=00; fault_clr is ignored in other states.
  - If both limits are still active after a clear, the next edge re-enters FAULT.
- Counters: width $clog2(max(DEADTIME, TRAVEL_TIMEOUT, RETRY_DELAY)+1), no wrap possible.
- rst asserted mid-travel: motors drop in the cycle after the rst edge, then IDLE. The next move still goes through DEAD.

Optional Feature:
- Macro: BLINDS_FAULT_RETRY_EN
- Defined:
  - A cause-01 fault auto-returns to IDLE after RETRY_DELAY cycles in FAULT, clearing fault and fault_cause, and sets internal retry_used.
  - A second timeout while retry_used=1 latches FAULT until fault_clr or rst.
  - retry_used clears on reaching the target limit, on fault_clr, and on rst.
  - Cause-10 faults never auto-retry.
- Undefined: all faults latch until fault_clr or rst, and RETRY_DELAY is unused.

Test Plan:
- Bench parameters: DEADTIME=4, TRAVEL_TIMEOUT=20.
1. Reset, both limits 0, blinds_open=0 -> after rst release DEAD for 4 cycles, then motor_down=1. Assert limit_closed -> motor_down falls 3 edges later (2 sync + 1 state), at_closed=1.
2. At closed (limit_closed=1), set blinds_open=1 -> motor_up rises exactly 4 cycles after IDLE samples it. Assert limit_open after 10 cycles -> IDLE, motor_up=0, at_open=1.
3. Reversal: OPENING for 5 cycles, drop blinds_open -> motor_up=0 next edge, 4 cycles with both motors 0, then motor_down=1. Never both high.
4. Timeout: OPENING with no limit -> motor_up high exactly 20 cycles, then fault=1, fault_cause=01. fault_clr pulse -> fault=0, and with blinds_open still 1 the bench sees DEAD then OPENING again.
5. Force limit_open=limit_closed=1 during CLOSING -> FAULT with cause 10, motor_down=0 within 3 edges. Same limit timing on cycle 20 of travel -> IDLE, no fault.
6. BLINDS_FAULT_RETRY_EN defined, RETRY_DELAY=8: first timeout -> auto-clears after 8 cycles and retries. Second timeout -> fault stays latched for 100+ cycles until fault_clr.
